// File: rtl/seq_multiplier_32bit_if.sv
// Start/Busy/Done handshake and HI/LO result bundle
// for the sequential multiplier.
interface seq_multiplier_32bit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             Signed;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, Signed, A, B,
    input  Busy, Done, Hi, Lo
  );

  modport slave (
    input  Start, Signed, A, B,
    output Busy, Done, Hi, Lo
  );
endinterface

// File: rtl/seq_multiplier_32bit.sv
// Radix-2 shift-add multiplier for mult/multu.
// Magnitudes are multiplied, the sign is applied in FIX.
module seq_multiplier_32bit #(
  parameter int WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  seq_multiplier_32bit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int PW = 2 * WIDTH + 1;

  localparam logic [1:0] SelHold     = 2'b00;
  localparam logic [1:0] SelLoad     = 2'b01;
  localparam logic [1:0] SelShift    = 2'b10;
  localparam logic [1:0] SelAddShift = 2'b11;

  typedef enum logic [1:0] {
    IDLE, CALC, FIX, DONE
  } state_t;

  state_t           state;
  logic [PW-1:0]    product;
  logic [WIDTH-1:0] magA;
  logic             negRes;
  logic [CW-1:0]    count;
  logic             busy;
  logic             done;

  logic             startOk;
  logic             inCalc;
  logic [1:0]       sel;
  logic [WIDTH-1:0] magAIn;
  logic [WIDTH-1:0] magBIn;
  logic [WIDTH:0]   sum;

  assign startOk = bus.Start &
                   (state == IDLE || state == DONE);
  assign inCalc  = (state == CALC);

  assign magAIn = (bus.Signed & bus.A[WIDTH-1]) ?
                  (~bus.A + WIDTH'(1)) : bus.A;
  assign magBIn = (bus.Signed & bus.B[WIDTH-1]) ?
                  (~bus.B + WIDTH'(1)) : bus.B;

  assign sum = {1'b0, product[2*WIDTH-1:WIDTH]}
             + {1'b0, magA};

  always_comb begin
    sel = SelHold;
    unique case (1'b1)
      startOk:                 sel = SelLoad;
      inCalc &&  product[0]:   sel = SelAddShift;
      inCalc && !product[0]:   sel = SelShift;
      default:                 sel = SelHold;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state   <= IDLE;
      product <= '0;
      magA    <= '0;
      negRes  <= 1'b0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      // FIX owns the product register; otherwise sel decides
      if (state == FIX) begin
        if (negRes)
          product[2*WIDTH-1:0] <= ~product[2*WIDTH-1:0]
                                + (2*WIDTH)'(1);
      end else begin
        case (sel)
          SelLoad:
            product <= {(WIDTH+1)'(0), magBIn};
          SelShift:
            product <= product >> 1;
          SelAddShift:
            product <= {sum, product[WIDTH-1:0]} >> 1;
          default:
            product <= product;
        endcase
      end

      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (bus.Start) begin
            magA   <= magAIn;
            negRes <= bus.Signed &
                      (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            count  <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end else begin
            state  <= IDLE;
          end
        end
        CALC: begin
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1))
            state <= FIX;
        end
        FIX: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy = busy;
  assign bus.Done = done;
  assign bus.Hi   = product[2*WIDTH-1:WIDTH];
  assign bus.Lo   = product[WIDTH-1:0];
endmodule

// File: tb/tb_seq_multiplier_32bit.sv
// Directed-vector bench for seq_multiplier_32bit:
// latency, unsigned/signed products, busy-ignore, reset.
module tb_seq_multiplier_32bit;
  logic Clk;
  logic ResetN;
  int   checks;
  int   failures;
  int   cyc;
  int   nDone;

  seq_multiplier_32bit_if #(.WIDTH(32)) bus ();

  seq_multiplier_32bit #(.WIDTH(32)) dut (
    .Clk    (Clk),
    .ResetN (ResetN),
    .bus    (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // wait for Done; cyc counts cycles since accept
  task automatic waitDone();
    while (!bus.Done && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  task automatic runOp(
    input string       tag,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        sgn,
    input logic [31:0] expHi,
    input logic [31:0] expLo
  );
    bus.Start  = 1'b1;
    bus.A      = a;
    bus.B      = b;
    bus.Signed = sgn;
    tick();
    bus.Start = 1'b0;
    cyc = 1;
    check({tag, ".busy"}, 64'(bus.Busy), 64'd1);
    waitDone();
    check({tag, ".lat"}, 64'(cyc), 64'd34);
    check({tag, ".hi"}, 64'(bus.Hi), 64'(expHi));
    check({tag, ".lo"}, 64'(bus.Lo), 64'(expLo));
    tick();
    check({tag, ".pulse"}, 64'(bus.Done), 64'd0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    ResetN     = 1'b0;
    bus.Start  = 1'b0;
    bus.Signed = 1'b0;
    bus.A      = '0;
    bus.B      = '0;
    repeat (3) tick();
    check("rst.busy", 64'(bus.Busy), 64'd0);
    check("rst.done", 64'(bus.Done), 64'd0);
    check("rst.hi",   64'(bus.Hi),   64'd0);
    check("rst.lo",   64'(bus.Lo),   64'd0);
    ResetN = 1'b1;
    tick();

    runOp("u3x5", 32'd3, 32'd5, 1'b0,
          32'h0, 32'hF);
    runOp("uMax", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0,
          32'hFFFFFFFE, 32'h1);
    runOp("sMin", 32'h80000000, 32'h80000000, 1'b1,
          32'h40000000, 32'h0);
    runOp("sNeg3x7", 32'hFFFFFFFD, 32'd7, 1'b1,
          32'hFFFFFFFF, 32'hFFFFFFEB);
    runOp("sM1xM1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
          32'h0, 32'h1);
    runOp("sZero", 32'h0, 32'hDEADBEEF, 1'b1,
          32'h0, 32'h0);

    // start while busy is ignored
    bus.Start  = 1'b1;
    bus.A      = 32'd2;
    bus.B      = 32'd9;
    bus.Signed = 1'b0;
    tick();
    bus.Start = 1'b0;
    cyc = 1;
    while (!bus.Done && cyc < 60) begin
      if (cyc == 10) begin
        bus.Start = 1'b1;
        bus.A     = 32'd100;
        bus.B     = 32'd100;
      end else begin
        bus.Start = 1'b0;
      end
      tick();
      cyc++;
    end
    check("ign.lat", 64'(cyc), 64'd34);
    check("ign.hi", 64'(bus.Hi), 64'd0);
    check("ign.lo", 64'(bus.Lo), 64'h12);

    // start held in DONE: back-to-back accept
    bus.Start = 1'b1;
    bus.A     = 32'd3;
    bus.B     = 32'd5;
    tick();
    check("b2b.busy", 64'(bus.Busy), 64'd1);
    check("b2b.done", 64'(bus.Done), 64'd0);
    bus.Start = 1'b0;
    cyc = 1;
    waitDone();
    check("b2b.lat", 64'(cyc), 64'd34);
    check("b2b.lo", 64'(bus.Lo), 64'hF);
    tick();

    // reset mid-CALC
    bus.Start = 1'b1;
    bus.A     = 32'h1234;
    bus.B     = 32'h5678;
    tick();
    bus.Start = 1'b0;
    repeat (14) tick();
    ResetN = 1'b0;
    tick();
    ResetN = 1'b1;
    check("mrst.busy", 64'(bus.Busy), 64'd0);
    check("mrst.done", 64'(bus.Done), 64'd0);
    check("mrst.hi",   64'(bus.Hi),   64'd0);
    check("mrst.lo",   64'(bus.Lo),   64'd0);
    nDone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.Done) nDone++;
    end
    check("mrst.nodone", 64'(nDone), 64'd0);
    runOp("post", 32'h1234, 32'h5678, 1'b0,
          32'h0, 32'h06260060);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
